spi_burst_memory: RTL and testbench

//  SPI mode-0 slave fronting an internal register-file memory, all logic in the clk domain.

---
 rtl/spi_mem_pkg.sv | 26 ++
 rtl/spi_pin_sync.sv | 37 +++
 rtl/spi_burst_memory.sv | 185 ++++++++++++++++++
 tb/tb_spi_burst_memory.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_mem_pkg.sv
// Shared encodings for the SPI burst memory: FSM state values, the R/W command bit
// polarity, and a small sizing helper.
package spi_mem_pkg;

    localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
    localparam logic [2:0] ST_CMD_ENC   = 3'd1;
    localparam logic [2:0] ST_WRITE_ENC = 3'd2;
    localparam logic [2:0] ST_READ_ENC  = 3'd3;
    localparam logic [2:0] ST_DONE_ENC  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE_ENC,
        S_CMD   = ST_CMD_ENC,
        S_WRITE = ST_WRITE_ENC,
        S_READ  = ST_READ_ENC,
        S_DONE  = ST_DONE_ENC
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with single-clock rise/fall
// pulses taken one flop after the synchronised level.
module spi_pin_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pin};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_burst_memory.sv
// SPI mode-0 slave in front of a register-file memory: address/R-W command, then
// word-wise writes or reads with optional address auto-increment per word.
module spi_burst_memory
    import spi_mem_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int BURST       = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk_pin,
    input  logic       cs_pin,
    input  logic       mosi_pin,
    output logic       miso_pin,
    output logic       miso_oe,
    output logic [3:0] leds
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int SH_W  = max_i(ADDR_W, DATA_W);
    localparam int CNT_W = $clog2(max_i(ADDR_W, DATA_W) + 1);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .pin(sclk_pin),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );
    // CS idles high, so its synchroniser resets high to avoid a false frame start.
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset(reset), .pin(cs_pin),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .pin(mosi_pin),
        .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sclk_lvl, cs_lvl, mosi_rise, mosi_fall};

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [SH_W-1:0]        shift_q, shift_d;
    logic [DATA_W-1:0]      wr_data_q, wr_data_d;
    logic                   wr_pend_q, wr_pend_d;
    logic                   ld_pend_q, ld_pend_d;
    logic                   miso_q, miso_d;
    logic                   oe_q, oe_d;
    logic                   wrap_q, wrap_d;
    logic [DATA_W-1:0]      mem [DEPTH];
    logic [DATA_W-1:0]      rd_word;

    assign rd_word = mem[addr_q];

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        addr_d    = addr_q;
        shift_d   = shift_q;
        wr_data_d = wr_data_q;
        wr_pend_d = 1'b0;
        ld_pend_d = 1'b0;
        miso_d    = miso_q;
        oe_d      = oe_q;
        wrap_d    = wrap_q;

        // A completed word commits this cycle; in burst mode the address moves on with it.
        if (wr_pend_q && (BURST != 0)) begin
            addr_d = addr_q + ADDR_W'(1);
            if (&addr_q) wrap_d = 1'b1;
        end
        if (ld_pend_q) shift_d = SH_W'(rd_word);

        if (cs_rise) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            oe_d      = 1'b0;
            miso_d    = 1'b0;
        end else if (cs_fall) begin
            state_d   = S_CMD;
            bit_cnt_d = '0;
            oe_d      = 1'b0;
            miso_d    = 1'b0;
            wrap_d    = 1'b0;
        end else begin
            unique case (state_q)
                S_CMD: begin
                    if (sclk_rise) begin
                        shift_d = {shift_q[SH_W-2:0], mosi_lvl};
                        if (bit_cnt_q == CNT_W'(ADDR_W)) begin
                            addr_d    = shift_q[ADDR_W-1:0];
                            bit_cnt_d = '0;
                            if (mosi_lvl == RW_READ) begin
                                state_d   = S_READ;
                                ld_pend_d = 1'b1;
                            end else begin
                                state_d = S_WRITE;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_WRITE: begin
                    if (sclk_rise) begin
                        shift_d = {shift_q[SH_W-2:0], mosi_lvl};
                        if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                            wr_pend_d = 1'b1;
                            wr_data_d = {shift_q[DATA_W-2:0], mosi_lvl};
                            bit_cnt_d = '0;
                            if (BURST == 0) state_d = S_DONE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_READ: begin
                    if (sclk_fall) begin
                        // Single-word mode keeps driving the LSB until the fall after it.
                        if ((BURST == 0) && (bit_cnt_q == CNT_W'(DATA_W))) begin
                            state_d = S_DONE;
                            oe_d    = 1'b0;
                        end else begin
                            oe_d    = 1'b1;
                            miso_d  = shift_q[DATA_W-1];
                            shift_d = {shift_q[SH_W-2:0], 1'b0};
                            if ((bit_cnt_q == CNT_W'(DATA_W - 1)) && (BURST != 0)) begin
                                bit_cnt_d = '0;
                                addr_d    = addr_q + ADDR_W'(1);
                                ld_pend_d = 1'b1;
                                if (&addr_q) wrap_d = 1'b1;
                            end else begin
                                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                end
                S_DONE: oe_d = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            addr_q    <= '0;
            wr_pend_q <= 1'b0;
            ld_pend_q <= 1'b0;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            addr_q    <= addr_d;
            wr_pend_q <= wr_pend_d;
            ld_pend_q <= ld_pend_d;
            miso_q    <= miso_d;
            oe_q      <= oe_d;
            wrap_q    <= wrap_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q   <= shift_d;
        wr_data_q <= wr_data_d;
    end

    always_ff @(posedge clk) begin
        if (wr_pend_q) mem[addr_q] <= wr_data_q;
    end

    assign miso_pin = miso_q;
    assign miso_oe  = oe_q;
    assign leds     = {wrap_q, state_q};

endmodule

// File: tb/tb_spi_burst_memory.sv
// Bench for spi_burst_memory: a burst build and a single-word build driven by an SPI
// master task, checked every settled window against a frame-level memory model.
module tb_spi_burst_memory;

    localparam int DEPTH = 128;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] cs   = 2'b11;
    logic [1:0] sclk = 2'b00;
    logic [1:0] mosi = 2'b00;
    logic [1:0] miso;
    logic [1:0] oe;
    logic [7:0] leds_all;

    always #5 clk = ~clk;

    spi_burst_memory #(.ADDR_W(7), .DATA_W(8), .BURST(1), .SYNC_STAGES(2)) u_burst (
        .clk(clk), .reset(rst), .sclk_pin(sclk[0]), .cs_pin(cs[0]), .mosi_pin(mosi[0]),
        .miso_pin(miso[0]), .miso_oe(oe[0]), .leds(leds_all[3:0])
    );
    spi_burst_memory #(.ADDR_W(7), .DATA_W(8), .BURST(0), .SYNC_STAGES(2)) u_single (
        .clk(clk), .reset(rst), .sclk_pin(sclk[1]), .cs_pin(cs[1]), .mosi_pin(mosi[1]),
        .miso_pin(miso[1]), .miso_oe(oe[1]), .leds(leds_all[7:4])
    );

    // Frame-level model: expected memory per build plus expected visible outputs.
    logic [7:0] mmem  [2][DEPTH];
    bit         known [2][DEPTH];
    int         exp_st   [2];
    bit         exp_wrap [2];
    bit         exp_oe   [2];
    bit         exp_miso [2];
    bit         exp_mk   [2];
    bit         chk = 1'b0;
    logic [7:0] wbuf [8];
    logic [7:0] rbuf [8];

    int vectors = 0;
    int miscompares = 0;

    task automatic cmp(input string nm, input int act, input int expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk) begin
            for (int s = 0; s < 2; s++) begin
                logic [3:0] lv;
                lv = leds_all[s*4 +: 4];
                cmp($sformatf("d%0d_state", s), int'(lv[2:0]), exp_st[s]);
                cmp($sformatf("d%0d_wrap", s), int'(lv[3]), int'(exp_wrap[s]));
                cmp($sformatf("d%0d_oe", s), int'(oe[s]), int'(exp_oe[s]));
                if (exp_oe[s] && exp_mk[s])
                    cmp($sformatf("d%0d_miso", s), int'(miso[s]), int'(exp_miso[s]));
            end
        end
    end

    task automatic half();
        repeat (6) @(posedge clk);
        chk = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk = 1'b0;
    endtask

    task automatic set_miso(input int s, input int base, input int f);
        int a;
        a = (base + f / 8) % DEPTH;
        exp_miso[s] = mmem[s][a][7 - f % 8];
        exp_mk[s]   = known[s][a];
    endtask

    task automatic do_reset_mid(input int s);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        cmp("rst_oe", int'(oe[s]), 0);
        cmp("rst_leds_burst", int'(leds_all[3:0]), 0);
        cmp("rst_leds_single", int'(leds_all[7:4]), 0);
        cs[s] = 1'b1;
        sclk[s] = 1'b0;
        mosi[s] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            exp_st[k] = 0;
            exp_wrap[k] = 1'b0;
            exp_oe[k] = 1'b0;
        end
        half();
    endtask

    task automatic frame(input int s, input int addr, input bit rd, input int nbits,
                         input int rst_after);
        bit b;
        int base, a, w, f;
        logic [7:0] cmd;
        b = (s == 0);
        base = addr % DEPTH;
        cs[s] = 1'b0;
        exp_st[s] = 1;
        exp_wrap[s] = 1'b0;
        exp_oe[s] = 1'b0;
        half();
        cmd = {base[6:0], rd};
        for (int i = 0; i < 8; i++) begin
            mosi[s] = cmd[7 - i];
            half();
            sclk[s] = 1'b1;
            if (i == 7) exp_st[s] = rd ? 3 : 2;
            half();
            sclk[s] = 1'b0;
            if (i == 7 && rd) begin
                exp_oe[s] = 1'b1;
                set_miso(s, base, 0);
            end
        end
        for (int j = 0; j < nbits; j++) begin
            mosi[s] = rd ? 1'b0 : wbuf[j / 8][7 - j % 8];
            half();
            if (rd) rbuf[j / 8][7 - j % 8] = miso[s];
            sclk[s] = 1'b1;
            if (!rd && j % 8 == 7 && exp_st[s] == 2) begin
                w = j / 8;
                a = (base + w) % DEPTH;
                mmem[s][a] = wbuf[w];
                known[s][a] = 1'b1;
                if (!b) exp_st[s] = 4;
                else if (a == DEPTH - 1) exp_wrap[s] = 1'b1;
            end
            half();
            sclk[s] = 1'b0;
            f = j + 1;
            if (rd && exp_st[s] == 3) begin
                if (!b && f == 8) begin
                    exp_st[s] = 4;
                    exp_oe[s] = 1'b0;
                end else begin
                    set_miso(s, base, f);
                    if (b && f % 8 == 7 && (base + f / 8) % DEPTH == DEPTH - 1)
                        exp_wrap[s] = 1'b1;
                end
            end
            if (j == rst_after) begin
                do_reset_mid(s);
                return;
            end
        end
        half();
        cs[s] = 1'b1;
        exp_st[s] = 0;
        exp_oe[s] = 1'b0;
        half();
        half();
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            exp_st[s] = 0;
            exp_wrap[s] = 1'b0;
            exp_oe[s] = 1'b0;
            exp_miso[s] = 1'b0;
            exp_mk[s] = 1'b0;
            for (int a = 0; a < DEPTH; a++) begin
                known[s][a] = 1'b0;
                mmem[s][a] = '0;
            end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp("reset_leds", int'(leds_all), 0);
        cmp("reset_oe", int'(oe), 0);
        cmp("reset_miso", int'(miso), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        half();

        // Single write then read back.
        wbuf[0] = 8'h5A;
        frame(0, 'h12, 1'b0, 8, -1);
        frame(0, 'h12, 1'b1, 8, -1);
        cmp("read_0x12", int'(rbuf[0]), 'h5A);

        // Burst write across the top of memory, then burst read it back.
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
        frame(0, 'h7E, 1'b0, 24, -1);
        cmp("wrap_after_burst_wr", int'(leds_all[3]), 1);
        frame(0, 'h7E, 1'b1, 24, -1);
        cmp("burst_rd0", int'(rbuf[0]), 'h11);
        cmp("burst_rd1", int'(rbuf[1]), 'h22);
        cmp("burst_rd2", int'(rbuf[2]), 'h33);

        // Aborted write leaves the old word in place.
        wbuf[0] = 8'hA5;
        frame(0, 'h05, 1'b0, 8, -1);
        wbuf[0] = 8'h3C;
        frame(0, 'h05, 1'b0, 5, -1);
        cmp("abort_state_idle", int'(leds_all[2:0]), 0);
        frame(0, 'h05, 1'b1, 8, -1);
        cmp("abort_keeps_a5", int'(rbuf[0]), 'hA5);

        // Single-word build: second word of a frame is ignored.
        wbuf[0] = 8'h77;
        frame(1, 'h11, 1'b0, 8, -1);
        wbuf[0] = 8'h01; wbuf[1] = 8'h02;
        frame(1, 'h10, 1'b0, 16, -1);
        frame(1, 'h10, 1'b1, 8, -1);
        cmp("single_rd_0x10", int'(rbuf[0]), 'h01);
        frame(1, 'h11, 1'b1, 16, -1);
        cmp("single_rd_0x11", int'(rbuf[0]), 'h77);

        // Reset in the middle of a read, then a clean read.
        frame(0, 'h12, 1'b1, 8, 3);
        frame(0, 'h12, 1'b1, 8, -1);
        cmp("read_after_reset", int'(rbuf[0]), 'h5A);

        // Randomised frames on either build.
        for (int k = 0; k < 8; k++) begin
            int s, addr, nw;
            bit rd;
            s = int'($urandom_range(0, 1));
            addr = int'($urandom_range(0, DEPTH - 1));
            nw = int'($urandom_range(1, 3));
            rd = 1'($urandom_range(0, 1));
            for (int w = 0; w < 8; w++) wbuf[w] = 8'($urandom);
            frame(s, addr, rd, nw * 8, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
